// File: rtl/axis_frame_collector_pkg.sv
// Shared types and elaboration helpers for the AXIS frame collector.
`default_nettype none

package axis_frame_collector_pkg;

   typedef enum logic [0:0] {
      FILL      = 1'b0,
      FULL_WAIT = 1'b1
   } state_e;

   function automatic int words_f(input int data_width, input int in_width);
      return data_width / in_width;
   endfunction

   function automatic int idx_w_f(input int words);
      return $clog2(words);
   endfunction

endpackage

`default_nettype wire

// File: rtl/axis_frame_collector_if.sv
// Word-in / frame-out bundle between core, collector and C2H packager.
`default_nettype none

interface axis_frame_collector_if #(
   parameter int DATA_WIDTH = 16000,
   parameter int IN_WIDTH   = 64
);
   import axis_frame_collector_pkg::*;

   localparam int IDX_W = idx_w_f(words_f(DATA_WIDTH, IN_WIDTH));

   logic                  in_valid;
   logic                  in_ready;
   logic [IN_WIDTH-1:0]   in_data;
   logic                  in_flush;
   logic                  data_valid;
   logic                  data_next;
   logic [DATA_WIDTH-1:0] data;
   logic [31:0]           frame_cnt;
   logic [IDX_W:0]        fill_words;

   modport slave (
      input  in_valid, in_data, in_flush, data_next,
      output in_ready, data_valid, data, frame_cnt, fill_words
   );

   modport master (
      output in_valid, in_data, in_flush, data_next,
      input  in_ready, data_valid, data, frame_cnt, fill_words
   );

endinterface

`default_nettype wire

// File: rtl/axis_frame_collector_flush_timer.sv
// Idle counter that expires after FLUSH_TIMEOUT enabled cycles; tied off when the timeout is 0.
`default_nettype none

module axis_frame_collector_flush_timer #(
   parameter int FLUSH_TIMEOUT = 1024
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic clr_i,
   output logic expire_o
);

   if (FLUSH_TIMEOUT == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = clk_i ^ rst_i ^ en_i ^ clr_i;
      assign expire_o      = 1'b0;
   end else begin : g_on
      localparam int CW = $clog2(FLUSH_TIMEOUT + 1);

      logic [CW-1:0] cnt_q, cnt_d;

      assign expire_o = (cnt_q == CW'(FLUSH_TIMEOUT));

      // Expiry self-clears so the flush lasts exactly one cycle.
      always_comb begin
         cnt_d = cnt_q;
         if (expire_o || clr_i) begin
            cnt_d = '0;
         end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
         end
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/axis_frame_collector.sv
// Packs IN_WIDTH words into DATA_WIDTH frames (word 0 in LSBs); an assembly and a hold register
// let filling continue while a finished frame waits for the packager.
`default_nettype none

module axis_frame_collector
   import axis_frame_collector_pkg::*;
#(
   parameter int DATA_WIDTH    = 16000,
   parameter int IN_WIDTH      = 64,
   parameter int FLUSH_TIMEOUT = 1024
) (
   input  logic                   m_axis_c2h_aclk,
   input  logic                   rst,
   axis_frame_collector_if.slave  bus
);

   localparam int WORDS = words_f(DATA_WIDTH, IN_WIDTH);
   localparam int IDX_W = idx_w_f(WORDS);
   localparam int CW    = IDX_W + 1;

   if (DATA_WIDTH % IN_WIDTH != 0) begin : g_bad_width
      $error("DATA_WIDTH must be a multiple of IN_WIDTH");
   end

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] asm_q, asm_d, hold_q, hold_d;
   logic                  hold_valid_q, hold_valid_d;
   logic                  data_valid_q, data_valid_d;
   logic [31:0]           frame_cnt_q, frame_cnt_d;
   logic [CW-1:0]         cnt_q, cnt_d;

   logic                  accept, expire, hold_free, close;
   logic [DATA_WIDTH-1:0] asm_fill;
   logic [CW-1:0]         cnt_fill;

   assign bus.in_ready   = (state_q == FILL);
   assign bus.data_valid = data_valid_q;
   assign bus.data       = hold_q;
   assign bus.frame_cnt  = frame_cnt_q;
   assign bus.fill_words = cnt_q;

   assign accept    = bus.in_valid && bus.in_ready;
   assign hold_free = !hold_valid_q && !data_valid_q;

   axis_frame_collector_flush_timer #(
      .FLUSH_TIMEOUT (FLUSH_TIMEOUT)
   ) u_timer (
      .clk_i    (m_axis_c2h_aclk),
      .rst_i    (rst),
      .en_i     ((state_q == FILL) && (cnt_q != '0) && !accept),
      .clr_i    (accept),
      .expire_o (expire)
   );

   always_comb begin
      asm_fill = asm_q;
      for (int w = 0; w < WORDS; w++) begin
         if (accept && (cnt_q == CW'(w))) begin
            asm_fill[w*IN_WIDTH +: IN_WIDTH] = bus.in_data;
         end
      end
      cnt_fill = cnt_q + CW'(accept);
      // A flush arriving with the frame's last word still yields one close.
      close = (state_q == FILL) &&
              ((cnt_fill == CW'(WORDS)) || ((bus.in_flush || expire) && (cnt_fill != '0)));
   end

   always_comb begin
      state_d      = state_q;
      asm_d        = asm_q;
      cnt_d        = cnt_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      data_valid_d = 1'b0;
      frame_cnt_d  = frame_cnt_q + 32'(data_valid_q);

      if (hold_valid_q && bus.data_next) begin
         data_valid_d = 1'b1;
         hold_valid_d = 1'b0;
      end

      case (state_q)
         FILL: begin
            asm_d = asm_fill;
            cnt_d = cnt_fill;
            if (close) begin
               if (hold_free) begin
                  hold_d       = asm_fill;
                  hold_valid_d = 1'b1;
                  asm_d        = '0;
                  cnt_d        = '0;
               end else begin
                  state_d = FULL_WAIT;
               end
            end
         end
         FULL_WAIT: begin
            if (hold_free) begin
               hold_d       = asm_q;
               hold_valid_d = 1'b1;
               asm_d        = '0;
               cnt_d        = '0;
               state_d      = FILL;
            end
         end
      endcase
   end

   always_ff @(posedge m_axis_c2h_aclk) begin
      if (rst) begin
         state_q      <= FILL;
         asm_q        <= '0;
         cnt_q        <= '0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         data_valid_q <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         asm_q        <= asm_d;
         cnt_q        <= cnt_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         data_valid_q <= data_valid_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_axis_frame_collector.sv
// Scoreboard bench for axis_frame_collector: 4-word frames, 16-cycle flush timeout, plus a timeout-disabled instance.
`default_nettype none

module tb_axis_frame_collector;

   localparam int DW = 256;
   localparam int IW = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axis_frame_collector_if #(.DATA_WIDTH(DW), .IN_WIDTH(IW)) b ();
   axis_frame_collector_if #(.DATA_WIDTH(DW), .IN_WIDTH(IW)) b0 ();

   axis_frame_collector #(.DATA_WIDTH(DW), .IN_WIDTH(IW), .FLUSH_TIMEOUT(16)) dut (
      .m_axis_c2h_aclk (clk),
      .rst             (rst),
      .bus             (b)
   );

   axis_frame_collector #(.DATA_WIDTH(DW), .IN_WIDTH(IW), .FLUSH_TIMEOUT(0)) dut0 (
      .m_axis_c2h_aclk (clk),
      .rst             (rst),
      .bus             (b0)
   );

   int            checks  = 0;
   int            errors  = 0;
   int            dv0_cnt = 0;
   logic          prev_dv = 1'b0;
   logic [DW-1:0] exp_q[$];

   function automatic logic [DW-1:0] mk(input logic [63:0] w3, input logic [63:0] w2,
                                        input logic [63:0] w1, input logic [63:0] w0);
      return {w3, w2, w1, w0};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every strobe pops the oldest expected frame.
   always @(negedge clk) begin
      if (!rst) begin
         if (b.data_valid) begin
            checks++;
            if (prev_dv) begin
               errors++;
               $display("FAIL dv_adjacent: data_valid high 2 cycles running, expected 1");
            end
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_frame: got %h, expected no frame", b.data);
            end else begin
               logic [DW-1:0] e;
               e = exp_q.pop_front();
               if (b.data !== e) begin
                  errors++;
                  $display("FAIL frame_data: got %h, expected %h", b.data, e);
               end
            end
         end
         if (b0.data_valid) dv0_cnt++;
      end
      prev_dv = b.data_valid;
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [63:0] w, input logic fl);
      int n = 0;
      b.in_valid = 1'b1;
      b.in_data  = w;
      b.in_flush = fl;
      while (!b.in_ready && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!b.in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready got 0, expected 1");
      end else begin
         @(posedge clk);
         #1;
      end
      b.in_valid = 1'b0;
      b.in_flush = 1'b0;
      b.in_data  = '0;
   endtask

   task automatic pulse_flush();
      b.in_flush = 1'b1;
      idle(1);
      b.in_flush = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_in_ready"},   b.in_ready, 1);
      check({tag, "_data_valid"}, b.data_valid, 0);
      check({tag, "_data_nz"},    {63'b0, (b.data != '0)}, 0);
      check({tag, "_frame_cnt"},  b.frame_cnt, 0);
      check({tag, "_fill"},       b.fill_words, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      b.in_valid   = 1'b0;  b.in_data  = '0; b.in_flush  = 1'b0; b.data_next  = 1'b0;
      b0.in_valid  = 1'b0;  b0.in_data = '0; b0.in_flush = 1'b0; b0.data_next = 1'b1;

      rst = 1'b1;
      idle(3);
      check_reset_values("rst");
      rst = 1'b0;
      idle(1);

      // 1: full frame, latency and ordering of words
      b.data_next = 1'b1;
      exp_q.push_back(mk(64'h44, 64'h33, 64'h22, 64'h11));
      send(64'h11, 0); send(64'h22, 0); send(64'h33, 0); send(64'h44, 0);
      check("t1_fill_after_close", b.fill_words, 0);
      check("t1_dv_early", b.data_valid, 0);
      idle(1);
      check("t1_dv_latency", b.data_valid, 1);
      idle(1);
      check("t1_frame_cnt", b.frame_cnt, 1);

      // 2: backpressure, hold + FULL_WAIT
      b.data_next = 1'b0;
      for (int f = 0; f < 3; f++) begin
         exp_q.push_back(mk(64'h104 + 4*f, 64'h103 + 4*f, 64'h102 + 4*f, 64'h101 + 4*f));
      end
      for (int k = 1; k <= 8; k++) send(64'h100 + k, 0);
      check("t2_in_ready_wait", b.in_ready, 0);
      check("t2_fill_full", b.fill_words, 4);
      idle(8);
      check("t2_no_pulse", b.frame_cnt, 1);
      b.data_next = 1'b1;
      for (int k = 9; k <= 12; k++) send(64'h100 + k, 0);
      idle(12);
      check("t2_frame_cnt", b.frame_cnt, 4);
      check("t2_in_ready", b.in_ready, 1);

      // 3: partial flush with zero padding; flush on empty ignored
      exp_q.push_back(mk(64'h0, 64'h0, 64'hB, 64'hA));
      send(64'hA, 0); send(64'hB, 0);
      check("t3_fill", b.fill_words, 2);
      pulse_flush();
      idle(4);
      check("t3_frame_cnt", b.frame_cnt, 5);
      pulse_flush();
      idle(4);
      check("t3_empty_flush", b.frame_cnt, 5);

      // 4: flush together with the filling word, and with a partial word
      exp_q.push_back(mk(64'hC, 64'h3, 64'h2, 64'h1));
      send(64'h1, 0); send(64'h2, 0); send(64'h3, 0); send(64'hC, 1);
      idle(4);
      check("t4_single_close", b.frame_cnt, 6);
      check("t4_fill", b.fill_words, 0);
      exp_q.push_back(mk(64'h0, 64'h0, 64'hD, 64'hE));
      send(64'hE, 0); send(64'hD, 1);
      idle(4);
      check("t4_partial_flush", b.frame_cnt, 7);

      // 5: auto-flush on idle timeout
      exp_q.push_back(mk(64'h0, 64'h53, 64'h52, 64'h51));
      send(64'h51, 0); send(64'h52, 0); send(64'h53, 0);
      idle(16);
      check("t5_before_timeout", b.fill_words, 3);
      idle(1);
      check("t5_timeout_close", b.fill_words, 0);
      idle(3);
      check("t5_frame_cnt", b.frame_cnt, 8);

      b0.in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         b0.in_data = 64'h90 + k;
         idle(1);
      end
      b0.in_valid = 1'b0;
      idle(40);
      check("t5_no_timeout_fill", b0.fill_words, 3);
      check("t5_no_timeout_cnt", b0.frame_cnt, 0);

      // 6: reset with a held frame and a partial frame
      b.data_next = 1'b0;
      for (int k = 1; k <= 4; k++) send(64'h60 + k, 0);
      for (int k = 1; k <= 3; k++) send(64'h70 + k, 0);
      check("t6_fill_pre", b.fill_words, 3);
      rst = 1'b1;
      idle(2);
      check_reset_values("t6_rst");
      rst = 1'b0;
      b.data_next = 1'b1;
      idle(6);
      check("t6_no_strobe", b.frame_cnt, 0);
      exp_q.push_back(mk(64'h84, 64'h83, 64'h82, 64'h81));
      for (int k = 1; k <= 4; k++) send(64'h80 + k, 0);
      idle(4);
      check("t6_frame_cnt", b.frame_cnt, 1);

      check("sb_empty", exp_q.size(), 0);
      check("t5_no_timeout_pulses", dv0_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
